alu_ctrl_seq: RTL and testbench

//  Registered, handshaked ALU controller for the multi-cycle datapath. Decodes ALUOp_i/funct_i

---
 rtl/alu_ctrl_seq.sv | 155 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered, handshaked ALU control decoder with multi-cycle MULT/DIV sequencing
module alu_ctrl_seq #(
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6,
  parameter bit EN_SHIFT = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [2:0] ALUOp_i,
  input  logic [5:0] funct_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [3:0] ALUCtrl_o,
  output logic       illegal_o,
  output logic       multi_o,
  output logic       stall_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // The counter holds LAT-1 at accept so that leaving 1 lands valid_o exactly LAT edges later.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic             multi_q, multi_d;

  logic [3:0]       dec_ctrl;
  logic             dec_illegal;
  logic             dec_multi;
  logic [CNT_W-1:0] dec_load;
  logic             accept;

  always_comb begin
    dec_ctrl    = 4'b1111;
    dec_illegal = 1'b1;
    dec_multi   = 1'b0;
    dec_load    = '0;
    case (ALUOp_i)
      3'b000: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; end
      3'b001: begin dec_ctrl = 4'b0110; dec_illegal = 1'b0; end
      3'b011: begin dec_ctrl = 4'b0111; dec_illegal = 1'b0; end
      3'b100: begin dec_ctrl = 4'b0001; dec_illegal = 1'b0; end
      3'b101: begin dec_ctrl = 4'b0000; dec_illegal = 1'b0; end
      3'b010: begin
        case (funct_i)
          6'b100000: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; end
          6'b100010: begin dec_ctrl = 4'b0110; dec_illegal = 1'b0; end
          6'b100100: begin dec_ctrl = 4'b0000; dec_illegal = 1'b0; end
          6'b100101: begin dec_ctrl = 4'b0001; dec_illegal = 1'b0; end
          6'b101010: begin dec_ctrl = 4'b0111; dec_illegal = 1'b0; end
          6'b100111: begin dec_ctrl = 4'b1100; dec_illegal = 1'b0; end
          6'b000000: if (EN_SHIFT) begin dec_ctrl = 4'b1000; dec_illegal = 1'b0; end
          6'b000010: if (EN_SHIFT) begin dec_ctrl = 4'b1001; dec_illegal = 1'b0; end
          6'b011000: begin
            dec_ctrl    = 4'b1010;
            dec_illegal = 1'b0;
            dec_multi   = 1'b1;
            dec_load    = MUL_LOAD;
          end
          6'b011010: begin
            dec_ctrl    = 4'b1011;
            dec_illegal = 1'b0;
            dec_multi   = 1'b1;
            dec_load    = DIV_LOAD;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ready_o = (state_q == S_IDLE) | ((state_q == S_HOLD) & ready_i);
  assign accept  = valid_i & ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    multi_d   = multi_q;
    case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // An accept in HOLD overrides the drain to IDLE, giving back-to-back issue.
    if (accept) begin
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
      multi_d   = dec_multi;
      if (dec_multi) begin
        state_d = S_BUSY;
        cnt_d   = dec_load;
        valid_d = 1'b0;
      end else begin
        state_d = S_HOLD;
        cnt_d   = '0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      ctrl_q    <= 4'b0000;
      illegal_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      multi_q   <= multi_d;
    end
  end

  assign valid_o   = valid_q;
  assign ALUCtrl_o = ctrl_q;
  assign illegal_o = illegal_q;
  assign multi_o   = multi_q;
  assign stall_o   = (state_q == S_BUSY);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - randomized self-checking bench for alu_ctrl_seq against a table model
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [2:0] ALUOp_i = 3'b000;
  logic [5:0] funct_i = 6'b000000;

  logic       ready_o, valid_o, illegal_o, multi_o, stall_o;
  logic [3:0] ALUCtrl_o;
  logic       ns_ready_o, ns_valid_o, ns_illegal_o, ns_multi_o, ns_stall_o;
  logic [3:0] ns_ALUCtrl_o;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] atab [logic [2:0]];
  logic [3:0] rtab [logic [5:0]];

  alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6), .EN_SHIFT(1'b1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .valid_o(valid_o), .ready_i(ready_i),
    .ALUCtrl_o(ALUCtrl_o), .illegal_o(illegal_o), .multi_o(multi_o), .stall_o(stall_o)
  );

  alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6), .EN_SHIFT(1'b0)) u_ns (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ns_ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .valid_o(ns_valid_o), .ready_i(ready_i),
    .ALUCtrl_o(ns_ALUCtrl_o), .illegal_o(ns_illegal_o), .multi_o(ns_multi_o), .stall_o(ns_stall_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model(input logic [2:0] op, input logic [5:0] fn, input bit en_shift,
                                output logic [3:0] code, output logic ill, output logic mul,
                                output int lat);
    code = 4'b1111;
    ill  = 1'b1;
    mul  = 1'b0;
    lat  = 1;
    if (op == 3'b010) begin
      if (rtab.exists(fn) && (en_shift || !(fn == 6'h00 || fn == 6'h02))) begin
        code = rtab[fn];
        ill  = 1'b0;
      end
      if (fn == 6'h18) begin mul = 1'b1; lat = MUL_LAT; end
      if (fn == 6'h1A) begin mul = 1'b1; lat = DIV_LAT; end
    end else if (atab.exists(op)) begin
      code = atab[op];
      ill  = 1'b0;
    end
  endfunction

  // Called at posedge+1; returns edges from accept to valid_o and the outputs seen then.
  task automatic run_op(input logic [2:0] op, input logic [5:0] fn, output int lat,
                        output logic [3:0] code, output logic ill, output logic mul,
                        output logic [3:0] ns_code, output logic ns_ill);
    int w;
    ALUOp_i = op;
    funct_i = fn;
    valid_i = 1'b1;
    w = 0;
    while (!ready_o && w < 100) begin
      @(posedge clk_i); #1;
      w++;
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    code    = ALUCtrl_o;
    ill     = illegal_o;
    mul     = multi_o;
    ns_code = ns_ALUCtrl_o;
    ns_ill  = ns_illegal_o;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({valid_o, ALUCtrl_o, illegal_o, multi_o, stall_o} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {valid_o, ALUCtrl_o, illegal_o, multi_o, stall_o});
    end
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b required 1", ready_o);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic check_op(input logic [2:0] op, input logic [5:0] fn, input bit check_ns);
    int lat, elat, nlat;
    logic [3:0] code, ecode, ns_code, ncode;
    logic ill, mul, ns_ill, eill, emul, nill, nmul;
    run_op(op, fn, lat, code, ill, mul, ns_code, ns_ill);
    model(op, fn, 1'b1, ecode, eill, emul, elat);
    model(op, fn, 1'b0, ncode, nill, nmul, nlat);
    vectors++;
    if (lat != elat) begin
      miscompares++;
      $display("FAIL latency op=%b fn=%b: got %0d required %0d", op, fn, lat, elat);
    end
    vectors++;
    if ({code, ill, mul} !== {ecode, eill, emul}) begin
      miscompares++;
      $display("FAIL decode op=%b fn=%b: got ctrl=%b ill=%b multi=%b required ctrl=%b ill=%b multi=%b",
               op, fn, code, ill, mul, ecode, eill, emul);
    end
    if (check_ns) begin
      vectors++;
      if ({ns_code, ns_ill} !== {ncode, nill}) begin
        miscompares++;
        $display("FAIL noshift_decode op=%b fn=%b: got ctrl=%b ill=%b required ctrl=%b ill=%b",
                 op, fn, ns_code, ns_ill, ncode, nill);
      end
    end
  endtask

  task automatic test_table;
    logic [5:0] functs [11];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h02, 6'h18, 6'h1A, 6'h3F};
    for (int op = 0; op < 8; op++) begin
      if (op != 2) check_op(3'(op), 6'($urandom_range(0, 63)), 1'b1);
    end
    foreach (functs[i]) check_op(3'b010, functs[i], 1'b1);
    for (int i = 0; i < 6; i++) check_op(3'b010, 6'($urandom_range(0, 63)), 1'b1);
  endtask

  task automatic test_random;
    logic [5:0] picks [10];
    picks = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h02, 6'h18, 6'h1A};
    for (int i = 0; i < 30; i++) begin
      logic [5:0] fn;
      if ($urandom_range(0, 1) == 0) fn = picks[$urandom_range(0, 9)];
      else fn = 6'($urandom_range(0, 63));
      check_op(3'($urandom_range(0, 7)), fn, 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [4];
    logic [3:0] exp_ctrl [4];
    ops      = '{3'b000, 3'b001, 3'b101, 3'b100};
    exp_ctrl = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ALUOp_i = ops[0];
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      vectors++;
      if (valid_o !== 1'b1 || ALUCtrl_o !== exp_ctrl[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got valid=%b ctrl=%b required valid=1 ctrl=%b",
                 i, valid_o, ALUCtrl_o, exp_ctrl[i]);
      end
      if (i < 3) ALUOp_i = ops[i+1];
      else valid_i = 1'b0;
    end
    @(posedge clk_i); #1;
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_drain: got valid=%b required 0", valid_o);
    end
  endtask

  task automatic test_multi;
    int lat;
    logic [3:0] code, ns_code;
    logic ill, mul, ns_ill;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ALUOp_i = 3'b010;
    funct_i = 6'b011000;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    for (int c = 1; c <= MUL_LAT - 1; c++) begin
      vectors++;
      if ({stall_o, ready_o, valid_o, multi_o, ALUCtrl_o} !== {4'b1001, 4'b1010}) begin
        miscompares++;
        $display("FAIL mult_busy cycle %0d: got stall=%b ready=%b valid=%b multi=%b ctrl=%b required 1 0 0 1 1010",
                 c, stall_o, ready_o, valid_o, multi_o, ALUCtrl_o);
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    vectors++;
    if ({valid_o, stall_o, multi_o, ALUCtrl_o} !== {3'b101, 4'b1010}) begin
      miscompares++;
      $display("FAIL mult_done: got valid=%b stall=%b multi=%b ctrl=%b required 1 0 1 1010",
               valid_o, stall_o, multi_o, ALUCtrl_o);
    end
    @(posedge clk_i); #1;
    run_op(3'b010, 6'b011010, lat, code, ill, mul, ns_code, ns_ill);
    vectors++;
    if (lat != DIV_LAT || mul !== 1'b1 || code !== 4'b1011) begin
      miscompares++;
      $display("FAIL div_latency: got lat=%0d multi=%b ctrl=%b required lat=%0d multi=1 ctrl=1011",
               lat, mul, code, DIV_LAT);
    end
  endtask

  task automatic test_backpressure;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    ALUOp_i = 3'b000;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    ALUOp_i = 3'b001;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (valid_o !== 1'b1 || ALUCtrl_o !== 4'b0010 || ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: got valid=%b ctrl=%b ready=%b required 1 0010 0",
                 c, valid_o, ALUCtrl_o, ready_o);
      end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    #1;
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_release_ready: got %b required 1", ready_o);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    vectors++;
    if (valid_o !== 1'b1 || ALUCtrl_o !== 4'b0110) begin
      miscompares++;
      $display("FAIL backpressure_next_op: got valid=%b ctrl=%b required 1 0110", valid_o, ALUCtrl_o);
    end
    @(posedge clk_i); #1;
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_drain: got valid=%b required 0", valid_o);
    end
  endtask

  task automatic test_reset_mid_busy;
    int lat;
    bit seen;
    logic [3:0] code, ns_code;
    logic ill, mul, ns_ill;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ALUOp_i = 3'b010;
    funct_i = 6'b011010;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    vectors++;
    if ({valid_o, ALUCtrl_o, illegal_o, multi_o, stall_o} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_busy: got %b required 00000000",
               {valid_o, ALUCtrl_o, illegal_o, multi_o, stall_o});
    end
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < DIV_LAT + 8; c++) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1 || stall_o === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset_abandon: got valid/stall after reset required none");
    end
    run_op(3'b000, 6'h00, lat, code, ill, mul, ns_code, ns_ill);
    vectors++;
    if (lat != 1 || code !== 4'b0010 || ill !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_accept: got lat=%0d ctrl=%b ill=%b required lat=1 ctrl=0010 ill=0",
               lat, code, ill);
    end
  endtask

  task automatic test_no_shift;
    int lat;
    logic [3:0] code, ns_code;
    logic ill, mul, ns_ill;
    @(posedge clk_i); #1;
    run_op(3'b010, 6'b000000, lat, code, ill, mul, ns_code, ns_ill);
    vectors++;
    if (ns_code !== 4'b1111 || ns_ill !== 1'b1 || code !== 4'b1000 || ill !== 1'b0) begin
      miscompares++;
      $display("FAIL no_shift_sll: got ns ctrl=%b ill=%b main ctrl=%b ill=%b required 1111 1 1000 0",
               ns_code, ns_ill, code, ill);
    end
  endtask

  initial begin
    atab[3'b000] = 4'b0010; atab[3'b001] = 4'b0110; atab[3'b011] = 4'b0111;
    atab[3'b100] = 4'b0001; atab[3'b101] = 4'b0000;
    rtab[6'h20] = 4'b0010; rtab[6'h22] = 4'b0110; rtab[6'h24] = 4'b0000;
    rtab[6'h25] = 4'b0001; rtab[6'h2A] = 4'b0111; rtab[6'h27] = 4'b1100;
    rtab[6'h00] = 4'b1000; rtab[6'h02] = 4'b1001; rtab[6'h18] = 4'b1010;
    rtab[6'h1A] = 4'b1011;
    test_reset();
    test_table();
    test_back_to_back();
    test_multi();
    test_backpressure();
    test_reset_mid_busy();
    test_no_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
